// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared widths and FSM state type for the data-memory responder
package dmem_pkg;
   localparam int DATA_W = 32;
   localparam int BE_W   = 4;
   localparam int WAIT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;
endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - request/response handshake bundle between the MEM stage and the responder
interface dmem_if;
   import dmem_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [31:0]       req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [BE_W-1:0]   req_be;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - DEPTH_WORDS x 32 storage, synchronous byte-lane write, combinational word read
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [BE_W-1:0]   be,
   input  logic [IDX_W-1:0]  idx,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < BE_W; i++) begin
            if (be[i]) r_mem[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = r_mem[idx];
endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data-memory responder with programmable wait states
// Optional access counters (ld_count/st_count/err_count) when DMEM_STATS_EN is defined.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst,
   dmem_if.slave       bus
`ifdef DMEM_STATS_EN
   ,
   output logic [15:0] ld_count,
   output logic [15:0] st_count,
   output logic [15:0] err_count
`endif
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   state_t            r_state;
   logic [WAIT_W-1:0] r_cnt;
   logic              r_we;
   logic              r_err;
   logic [IDX_W-1:0]  r_idx;
   logic [DATA_W-1:0] r_wdata;
   logic [BE_W-1:0]   r_be;
   logic              r_rsp_valid;
   logic              r_rsp_err;
   logic [DATA_W-1:0] r_rdata;

   logic              w_fault;
   logic              w_direct;
   logic              w_commit;
   logic              w_c_we;
   logic              w_c_err;
   logic [IDX_W-1:0]  w_c_idx;
   logic [DATA_W-1:0] w_c_wdata;
   logic [BE_W-1:0]   w_c_be;
   logic [DATA_W-1:0] w_rd;

   assign w_fault = (bus.req_addr[1:0] != 2'b00) ||
                    ({2'b00, bus.req_addr[31:2]} >= 32'(DEPTH_WORDS));

   // With no wait states the access commits on the accepting edge, so it must use the live request.
   assign w_direct  = (r_state == IDLE) && bus.req_valid && (WAIT_STATES == 0);
   assign w_commit  = w_direct || ((r_state == WAIT) && (r_cnt == '0));
   assign w_c_we    = w_direct ? bus.req_we                  : r_we;
   assign w_c_err   = w_direct ? w_fault                     : r_err;
   assign w_c_idx   = w_direct ? bus.req_addr[IDX_W+1:2]     : r_idx;
   assign w_c_wdata = w_direct ? bus.req_wdata               : r_wdata;
   assign w_c_be    = w_direct ? bus.req_be                  : r_be;

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .clk   (clk),
      .we    (w_commit && w_c_we && !w_c_err),
      .be    (w_c_be),
      .idx   (w_c_idx),
      .wdata (w_c_wdata),
      .rdata (w_rd)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_we        <= 1'b0;
         r_err       <= 1'b0;
         r_idx       <= '0;
         r_wdata     <= '0;
         r_be        <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rdata     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.req_valid) begin
                  r_we    <= bus.req_we;
                  r_err   <= w_fault;
                  r_idx   <= bus.req_addr[IDX_W+1:2];
                  r_wdata <= bus.req_wdata;
                  r_be    <= bus.req_be;
                  r_cnt   <= WAIT_INIT;
                  r_state <= (WAIT_STATES == 0) ? RESP : WAIT;
               end
            end
            WAIT: begin
               if (r_cnt == '0) r_state <= RESP;
               else             r_cnt   <= r_cnt - 1'b1;
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  r_state     <= IDLE;
                  r_rsp_valid <= 1'b0;
                  r_rsp_err   <= 1'b0;
                  r_rdata     <= '0;
               end
            end
            default: r_state <= IDLE;
         endcase

         if (w_commit) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_c_err;
            r_rdata     <= (w_c_we || w_c_err) ? '0 : w_rd;
         end
      end
   end

   assign bus.req_ready = (r_state == IDLE);
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_err   = r_rsp_err;
   assign bus.rsp_rdata = r_rdata;

`ifdef DMEM_STATS_EN
   logic [15:0] r_ld_cnt;
   logic [15:0] r_st_cnt;
   logic [15:0] r_err_cnt;
   logic        w_rsp_hs;

   assign w_rsp_hs = (r_state == RESP) && bus.rsp_ready;

   // A faulting access is counted only as an error, never as a load or store.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ld_cnt  <= '0;
         r_st_cnt  <= '0;
         r_err_cnt <= '0;
      end else if (w_rsp_hs) begin
         if (r_err) begin
            if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
         end else if (r_we) begin
            if (r_st_cnt != 16'hFFFF) r_st_cnt <= r_st_cnt + 16'd1;
         end else begin
            if (r_ld_cnt != 16'hFFFF) r_ld_cnt <= r_ld_cnt + 16'd1;
         end
      end
   end

   assign ld_count  = r_ld_cnt;
   assign st_count  = r_st_cnt;
   assign err_count = r_err_cnt;
`endif
endmodule
